// File: rtl/vc_write_buffer_pkg.sv
// vc_write_buffer_pkg: shared types for the victim-cache write-back buffer.
// Contents: LC-3b word/block types, the line tag type, the buffer entry
// struct, the buffer FSM state encoding and a line-address helper.
// No ports (package).
package vc_write_buffer_pkg;

  localparam int unsigned ADDR_W   = 16;
  localparam int unsigned LINE_W   = 128;
  localparam int unsigned OFFSET_W = 4;
  localparam int unsigned TAG_W    = ADDR_W - OFFSET_W;

  typedef logic [ADDR_W-1:0] lc3b_word;
  typedef logic [LINE_W-1:0] lc3b_block;
  typedef logic [TAG_W-1:0]  lc3b_line_tag;

  typedef struct packed {
    logic         valid;
    lc3b_line_tag tag;
    lc3b_block    data;
  } wb_entry;

  typedef enum logic [1:0] {
    S_IDLE      = 2'd0,
    S_ACK       = 2'd1,
    S_PMEM_READ = 2'd2,
    S_DRAIN     = 2'd3
  } wb_state_e;

  // Line-aligned address for a tag (offset bits forced to zero).
  function automatic lc3b_word line_addr(lc3b_line_tag tag);
    return {tag, OFFSET_W'(0)};
  endfunction

endpackage

// File: rtl/vc_write_buffer_wb_entry_array.sv
// wb_entry_array: circular store of buffered dirty lines.
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   lookup_tag_i             tag compared against every valid entry
//   hit_o/hit_idx_o/hit_data_o  match flag, index and data of matching entry
//   head_tag_o/head_data_o   oldest entry (next to drain)
//   full_o, empty_o          occupancy flags
//   enq_i/enq_tag_i/enq_data_i  append a new entry at the tail
//   ovw_i/ovw_idx_i/ovw_data_i  replace data of an existing entry
//   pop_i                    retire the head entry
module wb_entry_array
  import vc_write_buffer_pkg::*;
#(
  parameter  int unsigned DEPTH = 4,
  localparam int unsigned PTR_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  lc3b_line_tag     lookup_tag_i,
  output logic             hit_o,
  output logic [PTR_W-1:0] hit_idx_o,
  output lc3b_block        hit_data_o,
  output lc3b_line_tag     head_tag_o,
  output lc3b_block        head_data_o,
  output logic             full_o,
  output logic             empty_o,
  input  logic             enq_i,
  input  lc3b_line_tag     enq_tag_i,
  input  lc3b_block        enq_data_i,
  input  logic             ovw_i,
  input  logic [PTR_W-1:0] ovw_idx_i,
  input  lc3b_block        ovw_data_i,
  input  logic             pop_i
);

  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  wb_entry          entries_q [DEPTH];
  logic [PTR_W-1:0] head_q, tail_q;
  logic [CNT_W-1:0] count_q;

  // Parallel tag compare; at most one valid entry can match a tag.
  always_comb begin
    hit_o     = 1'b0;
    hit_idx_o = '0;
    for (int i = 0; i < int'(DEPTH); i++) begin
      if (!hit_o && entries_q[i].valid && entries_q[i].tag == lookup_tag_i) begin
        hit_o     = 1'b1;
        hit_idx_o = PTR_W'(i);
      end
    end
  end

  assign hit_data_o  = entries_q[hit_idx_o].data;
  assign head_tag_o  = entries_q[head_q].tag;
  assign head_data_o = entries_q[head_q].data;
  assign full_o      = (count_q == CNT_W'(DEPTH));
  assign empty_o     = (count_q == '0);

  // Storage and pointer update; the FSM never enqueues and pops together.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < int'(DEPTH); i++) entries_q[i] <= '0;
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      if (enq_i) begin
        entries_q[tail_q] <= '{valid: 1'b1, tag: enq_tag_i, data: enq_data_i};
        tail_q            <= tail_q + PTR_W'(1);
      end
      if (ovw_i) entries_q[ovw_idx_i].data <= ovw_data_i;
      if (pop_i) begin
        entries_q[head_q].valid <= 1'b0;
        head_q                  <= head_q + PTR_W'(1);
      end
      case ({enq_i, pop_i})
        2'b10:   count_q <= count_q + CNT_W'(1);
        2'b01:   count_q <= count_q - CNT_W'(1);
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/vc_write_buffer.sv
// vc_write_buffer: write-back buffer between the victim cache and memory.
// Absorbs line writes in one cycle, coalesces writes to buffered lines,
// drains entries to memory in FIFO order while upstream is idle, and passes
// read misses through to memory.
// Build option: VC_WB_READ_FORWARD_EN serves read hits from the buffer;
// without it a read hit drains the buffer until the line is gone, then
// reads memory.
// Ports:
//   clk, rst                        clock, synchronous active-high reset
//   mem_address/read/write/wdata    upstream request (level, held to mem_resp)
//   mem_rdata, mem_resp             upstream completion pulse and read data
//   pmem_address/read/write/wdata   memory request (held to pmem_resp)
//   pmem_rdata, pmem_resp           memory completion and read data
module vc_write_buffer
  import vc_write_buffer_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [15:0]   mem_address,
  input  logic          mem_read,
  input  logic          mem_write,
  input  logic [127:0]  mem_wdata,
  output logic [127:0]  mem_rdata,
  output logic          mem_resp,
  output logic [15:0]   pmem_address,
  output logic          pmem_read,
  output logic          pmem_write,
  output logic [127:0]  pmem_wdata,
  input  logic [127:0]  pmem_rdata,
  input  logic          pmem_resp
);

  localparam int unsigned PTR_W = $clog2(DEPTH);

  wb_state_e        state_q, state_d;
  logic             pmem_read_q, pmem_read_d;
  logic             pmem_write_q, pmem_write_d;
  lc3b_word         pmem_address_q, pmem_address_d;
  lc3b_block        pmem_wdata_q, pmem_wdata_d;
  logic             ack_q, ack_d;
  lc3b_block        ack_data_q, ack_data_d;

  lc3b_line_tag     req_tag;
  logic [3:0]       unused_addr_bits;
  logic             hit, full, empty;
  logic [PTR_W-1:0] hit_idx;
  lc3b_block        hit_data, head_data;
  lc3b_line_tag     head_tag;
  logic             enq, ovw, pop;
  logic             rd_done;

  assign req_tag          = mem_address[15:4];
  assign unused_addr_bits = mem_address[3:0];

`ifndef VC_WB_READ_FORWARD_EN
  lc3b_block unused_hit_data;
  assign unused_hit_data = hit_data;
`endif

  wb_entry_array #(.DEPTH(DEPTH)) u_entries (
    .clk          (clk),
    .rst          (rst),
    .lookup_tag_i (req_tag),
    .hit_o        (hit),
    .hit_idx_o    (hit_idx),
    .hit_data_o   (hit_data),
    .head_tag_o   (head_tag),
    .head_data_o  (head_data),
    .full_o       (full),
    .empty_o      (empty),
    .enq_i        (enq),
    .enq_tag_i    (req_tag),
    .enq_data_i   (mem_wdata),
    .ovw_i        (ovw),
    .ovw_idx_i    (hit_idx),
    .ovw_data_i   (mem_wdata),
    .pop_i        (pop)
  );

  // Next state, buffer strokes and next registered outputs.
  always_comb begin
    state_d    = state_q;
    enq        = 1'b0;
    ovw        = 1'b0;
    pop        = 1'b0;
    ack_data_d = '0;

    case (state_q)
      S_IDLE: begin
        if (mem_read) begin
          if (hit) begin
`ifdef VC_WB_READ_FORWARD_EN
            state_d    = S_ACK;
            ack_data_d = hit_data;
`else
            state_d    = S_DRAIN;
`endif
          end else begin
            state_d = S_PMEM_READ;
          end
        end else if (mem_write) begin
          if (hit) begin
            ovw     = 1'b1;
            state_d = S_ACK;
          end else if (!full) begin
            enq     = 1'b1;
            state_d = S_ACK;
          end else begin
            // Make room; the write is re-evaluated once back in idle.
            state_d = S_DRAIN;
          end
        end else if (!empty) begin
          state_d = S_DRAIN;
        end
      end
      S_ACK:       state_d = S_IDLE;
      S_PMEM_READ: if (pmem_resp) state_d = S_IDLE;
      S_DRAIN: begin
        if (pmem_resp) begin
          pop     = 1'b1;
          state_d = S_IDLE;
        end
      end
      default:     state_d = S_IDLE;
    endcase

    pmem_read_d    = (state_d == S_PMEM_READ);
    pmem_write_d   = (state_d == S_DRAIN);
    ack_d          = (state_d == S_ACK);
    pmem_address_d = '0;
    pmem_wdata_d   = '0;
    if (state_d == S_PMEM_READ) pmem_address_d = line_addr(req_tag);
    // Head is untouched until the pop, so drain outputs stay stable.
    if (state_d == S_DRAIN) begin
      pmem_address_d = line_addr(head_tag);
      pmem_wdata_d   = head_data;
    end
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= S_IDLE;
      pmem_read_q    <= 1'b0;
      pmem_write_q   <= 1'b0;
      pmem_address_q <= '0;
      pmem_wdata_q   <= '0;
      ack_q          <= 1'b0;
      ack_data_q     <= '0;
    end else begin
      state_q        <= state_d;
      pmem_read_q    <= pmem_read_d;
      pmem_write_q   <= pmem_write_d;
      pmem_address_q <= pmem_address_d;
      pmem_wdata_q   <= pmem_wdata_d;
      ack_q          <= ack_d;
      ack_data_q     <= ack_data_d;
    end
  end

  // Read misses complete in the same cycle memory responds.
  assign rd_done      = (state_q == S_PMEM_READ) && pmem_resp;
  assign mem_resp     = ack_q | rd_done;
  assign mem_rdata    = ack_q ? ack_data_q : (rd_done ? pmem_rdata : '0);
  assign pmem_read    = pmem_read_q;
  assign pmem_write   = pmem_write_q;
  assign pmem_address = pmem_address_q;
  assign pmem_wdata   = pmem_wdata_q;

endmodule

// File: tb/tb_vc_write_buffer.sv
// Directed bench for vc_write_buffer with a latency-programmable memory model.
module tb_vc_write_buffer;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [15:0]  mem_address = '0;
  logic         mem_read = 1'b0;
  logic         mem_write = 1'b0;
  logic [127:0] mem_wdata = '0;
  logic [127:0] mem_rdata;
  logic         mem_resp;
  logic [15:0]  pmem_address;
  logic         pmem_read;
  logic         pmem_write;
  logic [127:0] pmem_wdata;
  logic [127:0] pmem_rdata = '0;
  logic         pmem_resp = 1'b0;

  int checks = 0;
  int errors = 0;

  int           pm_lat = 2;
  logic [127:0] pm_rdata_cfg = '0;
  int           pm_cnt = 0;
  int           wr_n = 0;
  int           rd_n = 0;
  int           rd_hi = 0;
  logic [15:0]  wr_addr_q[$];
  logic [127:0] wr_data_q[$];
  logic [15:0]  rd_addr_q[$];
  bit           leak = 1'b0;

  localparam logic [127:0] GARBAGE = {4{32'hDEAD_BEEF}};

  vc_write_buffer dut (
    .clk          (clk),
    .rst          (rst),
    .mem_address  (mem_address),
    .mem_read     (mem_read),
    .mem_write    (mem_write),
    .mem_wdata    (mem_wdata),
    .mem_rdata    (mem_rdata),
    .mem_resp     (mem_resp),
    .pmem_address (pmem_address),
    .pmem_read    (pmem_read),
    .pmem_write   (pmem_write),
    .pmem_wdata   (pmem_wdata),
    .pmem_rdata   (pmem_rdata),
    .pmem_resp    (pmem_resp)
  );

  always #5 clk = ~clk;

  // Memory model: responds pm_lat cycles after a request appears.
  always @(posedge clk) begin
    #1;
    if (pmem_read || pmem_write) begin
      pm_cnt = pm_cnt + 1;
      if (pm_cnt == pm_lat) begin
        pmem_resp = 1'b1;
        if (pmem_write) begin
          wr_addr_q.push_back(pmem_address);
          wr_data_q.push_back(pmem_wdata);
          wr_n = wr_n + 1;
          pmem_rdata = GARBAGE;
        end else begin
          rd_addr_q.push_back(pmem_address);
          rd_n = rd_n + 1;
          pmem_rdata = pm_rdata_cfg;
        end
      end else begin
        pmem_resp  = 1'b0;
        pmem_rdata = GARBAGE;
      end
    end else begin
      pm_cnt     = 0;
      pmem_resp  = 1'b0;
      pmem_rdata = GARBAGE;
    end
  end

  always @(negedge clk) begin
    if (pmem_read) rd_hi = rd_hi + 1;
    if (!mem_resp && mem_rdata != '0) leak = 1'b1;
  end

  // Issue one upstream request; lat counts negedges until mem_resp (-1 on timeout).
  task automatic do_req(input bit wr, input logic [15:0] addr, input logic [127:0] wd,
                        output int lat, output logic [127:0] rd);
    mem_address = addr;
    mem_wdata   = wd;
    mem_write   = wr;
    mem_read    = ~wr;
    lat = -1;
    rd  = '0;
    for (int i = 1; i <= 300; i++) begin
      @(negedge clk);
      if (mem_resp) begin
        lat = i;
        rd  = mem_rdata;
        break;
      end
    end
    mem_read  = 1'b0;
    mem_write = 1'b0;
  endtask

  // Wait until memory traffic has been quiet for 8 cycles.
  task automatic wait_idle(input string name);
    int quiet = 0;
    for (int i = 0; i < 500 && quiet < 8; i++) begin
      @(negedge clk);
      if (!pmem_read && !pmem_write) quiet++;
      else quiet = 0;
    end
    checks++;
    if (quiet < 8) begin
      errors++;
      $display("FAIL %s_idle_timeout: quiet cycles %0d required 8", name, quiet);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    checks++; if (mem_resp !== 1'b0) begin errors++; $display("FAIL reset_mem_resp: got %b expected 0", mem_resp); end
    checks++; if (mem_rdata !== '0) begin errors++; $display("FAIL reset_mem_rdata: got %h expected 0", mem_rdata); end
    checks++; if (pmem_read !== 1'b0) begin errors++; $display("FAIL reset_pmem_read: got %b expected 0", pmem_read); end
    checks++; if (pmem_write !== 1'b0) begin errors++; $display("FAIL reset_pmem_write: got %b expected 0", pmem_write); end
    checks++; if (pmem_address !== 16'h0) begin errors++; $display("FAIL reset_pmem_address: got %h expected 0", pmem_address); end
    checks++; if (pmem_wdata !== '0) begin errors++; $display("FAIL reset_pmem_wdata: got %h expected 0", pmem_wdata); end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_write_drain();
    logic [127:0] a = {4{32'hA0A0_0001}};
    logic [127:0] rd;
    int lat, w0, r0;
    pm_lat = 2;
    w0 = wr_n; r0 = rd_n;
    do_req(1'b1, 16'h1230, a, lat, rd);
    checks++; if (lat !== 1) begin errors++; $display("FAIL wr_ack_latency: got %0d expected 1", lat); end
    checks++; if ((wr_n - w0 + rd_n - r0) !== 0 || pmem_write !== 1'b0) begin
      errors++; $display("FAIL wr_no_pmem_traffic: got %0d txns pmem_write=%b expected 0 0", wr_n - w0 + rd_n - r0, pmem_write);
    end
    wait_idle("wr");
    checks++; if ((wr_n - w0) !== 1) begin errors++; $display("FAIL wr_drain_count: got %0d expected 1", wr_n - w0); end
    if (wr_n - w0 >= 1) begin
      checks++; if (wr_addr_q[w0] !== 16'h1230) begin errors++; $display("FAIL wr_drain_addr: got %h expected 1230", wr_addr_q[w0]); end
      checks++; if (wr_data_q[w0] !== a) begin errors++; $display("FAIL wr_drain_data: got %h expected %h", wr_data_q[w0], a); end
    end
  endtask

  task automatic test_coalesce();
    logic [127:0] b = {4{32'hB0B0_0002}};
    logic [127:0] c = {4{32'hC0C0_0003}};
    logic [127:0] rd;
    int lat1, lat2, w0;
    pm_lat = 2;
    w0 = wr_n;
    do_req(1'b1, 16'h2000, b, lat1, rd);
    do_req(1'b1, 16'h2008, c, lat2, rd);
    checks++; if (lat1 !== 1) begin errors++; $display("FAIL coal_first_latency: got %0d expected 1", lat1); end
    // Back-to-back: one cycle to leave the ack state, one to accept.
    checks++; if (lat2 !== 2) begin errors++; $display("FAIL coal_second_latency: got %0d expected 2", lat2); end
    wait_idle("coal");
    checks++; if ((wr_n - w0) !== 1) begin errors++; $display("FAIL coal_drain_count: got %0d expected 1", wr_n - w0); end
    if (wr_n - w0 >= 1) begin
      checks++; if (wr_addr_q[w0] !== 16'h2000) begin errors++; $display("FAIL coal_drain_addr: got %h expected 2000", wr_addr_q[w0]); end
      checks++; if (wr_data_q[w0] !== c) begin errors++; $display("FAIL coal_drain_data: got %h expected %h", wr_data_q[w0], c); end
    end
  endtask

  task automatic test_full();
    logic [127:0] rd;
    int lat [5];
    int exp_lat [5] = '{1, 2, 2, 2, 6};
    int w0, w_after5;
    pm_lat = 3;
    w0 = wr_n;
    for (int i = 0; i < 5; i++)
      do_req(1'b1, 16'h5000 + 16'(i * 16), {4{32'h5A5A_0000 + 32'(i)}}, lat[i], rd);
    w_after5 = wr_n - w0;
    for (int i = 0; i < 5; i++) begin
      checks++; if (lat[i] !== exp_lat[i]) begin errors++; $display("FAIL full_latency_%0d: got %0d expected %0d", i, lat[i], exp_lat[i]); end
    end
    checks++; if (w_after5 !== 1) begin errors++; $display("FAIL full_drain_before_ack: got %0d expected 1", w_after5); end
    wait_idle("full");
    checks++; if ((wr_n - w0) !== 5) begin errors++; $display("FAIL full_drain_count: got %0d expected 5", wr_n - w0); end
    if (wr_n - w0 >= 5) begin
      for (int i = 0; i < 5; i++) begin
        checks++; if (wr_addr_q[w0+i] !== 16'h5000 + 16'(i * 16) || wr_data_q[w0+i] !== {4{32'h5A5A_0000 + 32'(i)}}) begin
          errors++; $display("FAIL full_drain_order_%0d: got %h/%h expected %h", i, wr_addr_q[w0+i], wr_data_q[w0+i], 16'h5000 + 16'(i * 16));
        end
      end
    end
  endtask

  task automatic test_read_miss();
    logic [127:0] e = {4{32'hE0E0_0005}};
    logic [127:0] rd;
    int lat, r0, w0, h0;
    pm_lat = 5; pm_rdata_cfg = e; leak = 1'b0;
    r0 = rd_n; w0 = wr_n; h0 = rd_hi;
    do_req(1'b0, 16'h4000, '0, lat, rd);
    @(negedge clk);
    checks++; if (lat !== 5) begin errors++; $display("FAIL miss_latency: got %0d expected 5", lat); end
    checks++; if (rd !== e) begin errors++; $display("FAIL miss_rdata: got %h expected %h", rd, e); end
    checks++; if ((rd_hi - h0) !== 5) begin errors++; $display("FAIL miss_pmem_read_cycles: got %0d expected 5", rd_hi - h0); end
    checks++; if ((rd_n - r0) !== 1 || (wr_n - w0) !== 0) begin errors++; $display("FAIL miss_txn_count: got %0d reads %0d writes expected 1 0", rd_n - r0, wr_n - w0); end
    if (rd_n - r0 >= 1) begin
      checks++; if (rd_addr_q[r0] !== 16'h4000) begin errors++; $display("FAIL miss_addr: got %h expected 4000", rd_addr_q[r0]); end
    end
    checks++; if (leak !== 1'b0) begin errors++; $display("FAIL rdata_without_resp: got %b expected 0", leak); end
  endtask

  task automatic test_read_hit();
    logic [127:0] d = {4{32'hD0D0_0004}};
    logic [127:0] h = {4{32'h1111_2222}};
    logic [127:0] rd;
    int lat_w, lat_r, r0, w0;
    pm_lat = 2; pm_rdata_cfg = h;
    r0 = rd_n; w0 = wr_n;
    do_req(1'b1, 16'h3000, d, lat_w, rd);
    do_req(1'b0, 16'h3004, '0, lat_r, rd);
    checks++; if (lat_w !== 1) begin errors++; $display("FAIL hit_write_latency: got %0d expected 1", lat_w); end
`ifdef VC_WB_READ_FORWARD_EN
    checks++; if (lat_r !== 2) begin errors++; $display("FAIL hit_fwd_latency: got %0d expected 2", lat_r); end
    checks++; if (rd !== d) begin errors++; $display("FAIL hit_fwd_rdata: got %h expected %h", rd, d); end
    checks++; if ((rd_n - r0) !== 0) begin errors++; $display("FAIL hit_fwd_no_pmem_read: got %0d expected 0", rd_n - r0); end
    wait_idle("hit");
    checks++; if ((wr_n - w0) !== 1) begin errors++; $display("FAIL hit_fwd_drain_count: got %0d expected 1", wr_n - w0); end
`else
    // ack->idle, idle->drain, 2-cycle drain, pop, 2-cycle read: 2 + 2 + 2 = 6
    checks++; if (lat_r !== 6) begin errors++; $display("FAIL hit_nofwd_latency: got %0d expected 6", lat_r); end
    checks++; if (rd !== h) begin errors++; $display("FAIL hit_nofwd_rdata: got %h expected %h", rd, h); end
    checks++; if ((wr_n - w0) !== 1 || (rd_n - r0) !== 1) begin errors++; $display("FAIL hit_nofwd_txns: got %0d writes %0d reads expected 1 1", wr_n - w0, rd_n - r0); end
    if (wr_n - w0 >= 1 && rd_n - r0 >= 1) begin
      checks++; if (wr_addr_q[w0] !== 16'h3000 || wr_data_q[w0] !== d) begin errors++; $display("FAIL hit_nofwd_drain: got %h/%h expected 3000/%h", wr_addr_q[w0], wr_data_q[w0], d); end
      checks++; if (rd_addr_q[r0] !== 16'h3000) begin errors++; $display("FAIL hit_nofwd_read_addr: got %h expected 3000", rd_addr_q[r0]); end
    end
    wait_idle("hit");
`endif
  endtask

  task automatic test_reset_mid_drain();
    logic [127:0] f = {4{32'hF0F0_0006}};
    logic [127:0] g = {4{32'h6666_7777}};
    logic [127:0] rd;
    int lat, w0, r0;
    bit seen = 1'b0;
    pm_lat = 20;
    w0 = wr_n;
    do_req(1'b1, 16'h6000, f, lat, rd);
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      if (pmem_write) seen = 1'b1;
    end
    checks++; if (seen !== 1'b1) begin errors++; $display("FAIL rst_drain_started: got %b expected 1", seen); end
    rst = 1'b1;
    @(negedge clk);
    checks++; if (pmem_write !== 1'b0 || pmem_address !== 16'h0 || pmem_wdata !== '0 || mem_resp !== 1'b0) begin
      errors++; $display("FAIL rst_mid_drain_outputs: got w=%b a=%h resp=%b expected 0 0 0", pmem_write, pmem_address, mem_resp);
    end
    rst = 1'b0;
    pm_lat = 2; pm_rdata_cfg = g;
    r0 = rd_n;
    do_req(1'b0, 16'h6000, '0, lat, rd);
    checks++; if ((wr_n - w0) !== 0) begin errors++; $display("FAIL rst_no_write: got %0d expected 0", wr_n - w0); end
    checks++; if (lat !== 2 || rd !== g) begin errors++; $display("FAIL rst_read_from_pmem: got lat %0d data %h expected 2 %h", lat, rd, g); end
    checks++; if ((rd_n - r0) !== 1) begin errors++; $display("FAIL rst_read_count: got %0d expected 1", rd_n - r0); end
    wait_idle("rst");
  endtask

  initial begin
    test_reset();
    test_write_drain();
    test_coalesce();
    test_full();
    test_read_miss();
    test_read_hit();
    test_reset_mid_drain();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
